// File: rtl/univ_shift_reg.sv
// Universal shift register: DEPTH lanes of WIDTH bits with shift up/down, parallel load,
// optional rotation, a registered tap output and a saturating fill counter.
module univ_shift_reg #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ROTATE = 0,
    localparam int TAP_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [WIDTH-1:0]         sin_up,
    input  logic [WIDTH-1:0]         sin_dn,
    input  logic [WIDTH*DEPTH-1:0]   par_in,
    input  logic [TAP_W-1:0]         tap_sel,
    output logic [WIDTH*DEPTH-1:0]   q,
    output logic [WIDTH-1:0]         sout_up,
    output logic [WIDTH-1:0]         sout_dn,
    output logic [WIDTH-1:0]         tap_out,
    output logic [CNT_W-1:0]         fill,
    output logic                     full
);

    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DN   = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;
    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(DEPTH);
    localparam int TAP_N = 2 ** TAP_W;

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [WIDTH-1:0] tap_mux [TAP_N];
    logic [WIDTH-1:0] tap_q, tap_d;
    logic [CNT_W-1:0] fill_q, fill_d;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] up_src;
            logic [WIDTH-1:0] dn_src;
            logic [WIDTH-1:0] nxt;

            // End stages take either the serial input or the opposite end when rotating.
            if (gi == 0) begin : g_up_end
                assign up_src = (ROTATE != 0) ? stage_q[DEPTH-1] : sin_up;
            end else begin : g_up_mid
                assign up_src = stage_q[gi-1];
            end

            if (gi == DEPTH - 1) begin : g_dn_end
                assign dn_src = (ROTATE != 0) ? stage_q[0] : sin_dn;
            end else begin : g_dn_mid
                assign dn_src = stage_q[gi+1];
            end

            always_comb begin
                nxt = stage_q[gi];
                if (en) begin
                    case (mode)
                        MODE_UP:   nxt = up_src;
                        MODE_DN:   nxt = dn_src;
                        MODE_LOAD: nxt = par_in[gi*WIDTH +: WIDTH];
                        default:   nxt = stage_q[gi];
                    endcase
                end
            end

            assign stage_d[gi]             = nxt;
            assign q[gi*WIDTH +: WIDTH]    = stage_q[gi];
        end

        // Tap indices past the last stage read as zero.
        for (genvar gi = 0; gi < TAP_N; gi++) begin : g_tap
            if (gi < DEPTH) begin : g_real
                assign tap_mux[gi] = stage_q[gi];
            end else begin : g_pad
                assign tap_mux[gi] = '0;
            end
        end
    endgenerate

    assign tap_d = tap_mux[tap_sel];

    always_comb begin
        fill_d = fill_q;
        if (en) begin
            case (mode)
                MODE_UP, MODE_DN: begin
                    if (ROTATE == 0 && fill_q != FILL_MAX) begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                MODE_LOAD: fill_d = FILL_MAX;
                default:   fill_d = fill_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            tap_q  <= '0;
            fill_q <= '0;
        end else begin
            stage_q <= stage_d;
            tap_q   <= tap_d;
            fill_q  <= fill_d;
        end
    end

    assign sout_up = stage_q[DEPTH-1];
    assign sout_dn = stage_q[0];
    assign tap_out = tap_q;
    assign fill    = fill_q;
    assign full    = (fill_q == FILL_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios plus random traffic on three instances
// (plain 4-stage, rotating 4-stage, plain 3-stage) against a queue-based reference model.
module tb_univ_shift_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en;
    logic [1:0]  mode;
    logic [7:0]  sin_up, sin_dn;
    logic [31:0] par_in;
    logic [1:0]  tap_sel;

    logic [31:0] q_a, q_r;
    logic [23:0] q_3;
    logic [7:0]  su_a, sd_a, tap_a, su_r, sd_r, tap_r, su_3, sd_3, tap_3;
    logic [2:0]  fill_a, fill_r;
    logic [1:0]  fill_3;
    logic        full_a, full_r, full_3;

    univ_shift_reg #(.WIDTH(8), .DEPTH(4), .ROTATE(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_up(sin_up), .sin_dn(sin_dn),
        .par_in(par_in), .tap_sel(tap_sel), .q(q_a), .sout_up(su_a), .sout_dn(sd_a),
        .tap_out(tap_a), .fill(fill_a), .full(full_a));

    univ_shift_reg #(.WIDTH(8), .DEPTH(4), .ROTATE(1)) dut_r (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_up(sin_up), .sin_dn(sin_dn),
        .par_in(par_in), .tap_sel(tap_sel), .q(q_r), .sout_up(su_r), .sout_dn(sd_r),
        .tap_out(tap_r), .fill(fill_r), .full(full_r));

    univ_shift_reg #(.WIDTH(8), .DEPTH(3), .ROTATE(0)) dut_3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_up(sin_up), .sin_dn(sin_dn),
        .par_in(par_in[23:0]), .tap_sel(tap_sel), .q(q_3), .sout_up(su_3), .sout_dn(sd_3),
        .tap_out(tap_3), .fill(fill_3), .full(full_3));

    int errors = 0;
    int checks = 0;

    // Reference model: index 0 of each queue is stage 0.
    logic [7:0] mq_a[$], mq_r[$], mq_3[$];
    int         fa, fr, f3;
    logic [7:0] ta, tr, t3;

    function automatic logic [31:0] pack(input logic [7:0] s[$]);
        logic [31:0] r = '0;
        foreach (s[i]) r[i*8 +: 8] = s[i];
        return r;
    endfunction

    task automatic model_step();
        logic [7:0] x;
        if (rst) begin
            mq_a = '{8'h0, 8'h0, 8'h0, 8'h0};
            mq_r = '{8'h0, 8'h0, 8'h0, 8'h0};
            mq_3 = '{8'h0, 8'h0, 8'h0};
            fa = 0; fr = 0; f3 = 0;
            ta = '0; tr = '0; t3 = '0;
        end else begin
            ta = mq_a[tap_sel];
            tr = mq_r[tap_sel];
            t3 = (tap_sel < 3) ? mq_3[tap_sel] : 8'h00;
            if (en) begin
                case (mode)
                    2'b01: begin
                        mq_a.push_front(sin_up); void'(mq_a.pop_back());
                        mq_3.push_front(sin_up); void'(mq_3.pop_back());
                        x = mq_r.pop_back(); mq_r.push_front(x);
                        fa = (fa < 4) ? fa + 1 : 4;
                        f3 = (f3 < 3) ? f3 + 1 : 3;
                    end
                    2'b10: begin
                        mq_a.push_back(sin_dn); void'(mq_a.pop_front());
                        mq_3.push_back(sin_dn); void'(mq_3.pop_front());
                        x = mq_r.pop_front(); mq_r.push_back(x);
                        fa = (fa < 4) ? fa + 1 : 4;
                        f3 = (f3 < 3) ? f3 + 1 : 3;
                    end
                    2'b11: begin
                        for (int i = 0; i < 4; i++) begin
                            mq_a[i] = par_in[i*8 +: 8];
                            mq_r[i] = par_in[i*8 +: 8];
                        end
                        for (int i = 0; i < 3; i++) mq_3[i] = par_in[i*8 +: 8];
                        fa = 4; fr = 4; f3 = 3;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 2'b11; par_in = 32'hDEADBEEF;
        sin_up = 8'h5A; sin_dn = 8'hA5; tap_sel = 2'd1;
        tick();
        tick();
        checks++; if (q_a !== 32'h0) begin errors++; $display("FAIL reset_q_a: got %h expected 00000000", q_a); end
        checks++; if (q_r !== 32'h0) begin errors++; $display("FAIL reset_q_r: got %h expected 00000000", q_r); end
        checks++; if (fill_a !== 3'd0 || full_a !== 1'b0) begin errors++; $display("FAIL reset_fill: got fill=%0d full=%b expected 0/0", fill_a, full_a); end
        checks++; if (tap_a !== 8'h0 || tap_3 !== 8'h0) begin errors++; $display("FAIL reset_tap: got %h/%h expected 00/00", tap_a, tap_3); end
        $display("reset: q_a=%h fill_a=%0d full_a=%b tap_a=%h", q_a, fill_a, full_a, tap_a);
    endtask

    task automatic test_shift_up();
        logic [7:0] v[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst = 1'b0; en = 1'b1; mode = 2'b01; tap_sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            sin_up = v[i];
            tick();
            checks++; if (fill_a !== 3'(i + 1)) begin errors++; $display("FAIL up_fill_a[%0d]: got %0d expected %0d", i, fill_a, i + 1); end
            checks++; if (full_a !== (i == 3)) begin errors++; $display("FAIL up_full_a[%0d]: got %b expected %b", i, full_a, i == 3); end
            checks++; if (fill_3 !== 2'((i < 3) ? i + 1 : 3)) begin errors++; $display("FAIL up_fill_3[%0d]: got %0d", i, fill_3); end
            $display("shift_up %0d: sin_up=%h q_a=%h fill_a=%0d full_a=%b", i, sin_up, q_a, fill_a, full_a);
        end
        checks++; if (q_a !== 32'h11223344) begin errors++; $display("FAIL up_q_a: got %h expected 11223344", q_a); end
        checks++; if (q_3 !== 24'h223344 || full_3 !== 1'b1) begin errors++; $display("FAIL up_q_3: got %h full=%b expected 223344 full=1", q_3, full_3); end
        checks++; if (su_a !== 8'h11) begin errors++; $display("FAIL up_sout_up: got %h expected 11", su_a); end
    endtask

    task automatic test_shift_down();
        logic [7:0] v[2] = '{8'hAA, 8'hBB};
        en = 1'b1; mode = 2'b10;
        for (int i = 0; i < 2; i++) begin
            sin_dn = v[i];
            tick();
            $display("shift_dn %0d: sin_dn=%h q_a=%h fill_a=%0d", i, sin_dn, q_a, fill_a);
        end
        checks++; if (q_a !== 32'hBBAA1122) begin errors++; $display("FAIL dn_q_a: got %h expected bbaa1122", q_a); end
        checks++; if (sd_a !== 8'h22) begin errors++; $display("FAIL dn_sout_dn: got %h expected 22", sd_a); end
        checks++; if (fill_a !== 3'd4 || full_a !== 1'b1) begin errors++; $display("FAIL dn_fill: got %0d/%b expected 4/1", fill_a, full_a); end
    endtask

    task automatic test_load_tap();
        en = 1'b1; mode = 2'b11; par_in = 32'h04030201; tap_sel = 2'd0;
        tick();
        $display("load: q_a=%h q_3=%h fill_a=%0d", q_a, q_3, fill_a);
        checks++; if (q_a !== 32'h04030201 || fill_a !== 3'd4) begin errors++; $display("FAIL load_q_a: got %h fill=%0d expected 04030201 fill=4", q_a, fill_a); end
        checks++; if (q_3 !== 24'h030201 || fill_3 !== 2'd3) begin errors++; $display("FAIL load_q_3: got %h fill=%0d expected 030201 fill=3", q_3, fill_3); end
        mode = 2'b00; tap_sel = 2'd2;
        tick();
        $display("tap sel=2: tap_a=%h tap_3=%h", tap_a, tap_3);
        checks++; if (tap_a !== 8'h03 || tap_3 !== 8'h03) begin errors++; $display("FAIL tap2: got %h/%h expected 03/03", tap_a, tap_3); end
        tap_sel = 2'd3;
        tick();
        $display("tap sel=3: tap_a=%h tap_3=%h", tap_a, tap_3);
        checks++; if (tap_a !== 8'h04) begin errors++; $display("FAIL tap3_a: got %h expected 04", tap_a); end
        checks++; if (tap_3 !== 8'h00) begin errors++; $display("FAIL tap3_oob: got %h expected 00", tap_3); end
    endtask

    task automatic test_enable_hold();
        en = 1'b0; mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            sin_up = 8'($urandom); tap_sel = 2'(i);
            tick();
            $display("hold %0d: q_a=%h fill_a=%0d tap_a=%h", i, q_a, fill_a, tap_a);
            checks++; if (q_a !== 32'h04030201 || fill_a !== 3'd4) begin errors++; $display("FAIL hold_q[%0d]: got %h fill=%0d expected 04030201 fill=4", i, q_a, fill_a); end
            checks++; if (tap_a !== 8'(i + 1)) begin errors++; $display("FAIL hold_tap[%0d]: got %h expected %h", i, tap_a, 8'(i + 1)); end
        end
    endtask

    task automatic test_reset_priority();
        en = 1'b1; mode = 2'b01; sin_up = 8'h5A;
        tick();
        rst = 1'b1; mode = 2'b11; par_in = 32'hFFFFFFFF; tap_sel = 2'd1;
        tick();
        rst = 1'b0;
        $display("reset_prio: q_a=%h q_r=%h fill_a=%0d full_a=%b tap_a=%h", q_a, q_r, fill_a, full_a, tap_a);
        checks++; if (q_a !== 32'h0 || q_r !== 32'h0) begin errors++; $display("FAIL rstprio_q: got %h/%h expected 0/0", q_a, q_r); end
        checks++; if (fill_a !== 3'd0 || full_a !== 1'b0 || fill_r !== 3'd0) begin errors++; $display("FAIL rstprio_fill: got %0d/%b/%0d expected 0/0/0", fill_a, full_a, fill_r); end
        checks++; if (tap_a !== 8'h0) begin errors++; $display("FAIL rstprio_tap: got %h expected 00", tap_a); end
    endtask

    task automatic test_rotate();
        en = 1'b1; mode = 2'b01; sin_up = 8'h77;
        tick();
        checks++; if (q_r !== 32'h0 || fill_r !== 3'd0) begin errors++; $display("FAIL rot_empty: got %h fill=%0d expected 0 fill=0", q_r, fill_r); end
        mode = 2'b11; par_in = 32'h04030201;
        tick();
        mode = 2'b01; sin_up = 8'hEE;
        tick();
        $display("rotate up: q_r=%h fill_r=%0d", q_r, fill_r);
        checks++; if (q_r !== 32'h03020104 || fill_r !== 3'd4) begin errors++; $display("FAIL rot_up: got %h fill=%0d expected 03020104 fill=4", q_r, fill_r); end
        mode = 2'b10; sin_dn = 8'hDD;
        tick();
        $display("rotate dn: q_r=%h fill_r=%0d", q_r, fill_r);
        checks++; if (q_r !== 32'h04030201 || fill_r !== 3'd4) begin errors++; $display("FAIL rot_dn: got %h fill=%0d expected 04030201 fill=4", q_r, fill_r); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            rst     = ($urandom_range(0, 39) == 0);
            en      = ($urandom_range(0, 3) != 0);
            mode    = 2'($urandom);
            sin_up  = 8'($urandom);
            sin_dn  = 8'($urandom);
            par_in  = $urandom;
            tap_sel = 2'($urandom);
            tick();
            $display("rand %0d: rst=%b en=%b mode=%b q_a=%h q_r=%h q_3=%h fill=%0d/%0d/%0d", n, rst, en, mode, q_a, q_r, q_3, fill_a, fill_r, fill_3);
            checks++;
            if ({q_a, su_a, sd_a, tap_a, fill_a, full_a} !== {pack(mq_a), mq_a[3], mq_a[0], ta, 3'(fa), fa == 4}) begin
                errors++;
                $display("FAIL rand_a[%0d]: got q=%h up=%h dn=%h tap=%h fill=%0d full=%b expected q=%h up=%h dn=%h tap=%h fill=%0d",
                         n, q_a, su_a, sd_a, tap_a, fill_a, full_a, pack(mq_a), mq_a[3], mq_a[0], ta, fa);
            end
            checks++;
            if ({q_r, su_r, sd_r, tap_r, fill_r, full_r} !== {pack(mq_r), mq_r[3], mq_r[0], tr, 3'(fr), fr == 4}) begin
                errors++;
                $display("FAIL rand_r[%0d]: got q=%h up=%h dn=%h tap=%h fill=%0d full=%b expected q=%h up=%h dn=%h tap=%h fill=%0d",
                         n, q_r, su_r, sd_r, tap_r, fill_r, full_r, pack(mq_r), mq_r[3], mq_r[0], tr, fr);
            end
            checks++;
            if ({q_3, su_3, sd_3, tap_3, fill_3, full_3} !== {pack(mq_3) & 32'h00FFFFFF, mq_3[2], mq_3[0], t3, 2'(f3), f3 == 3}) begin
                errors++;
                $display("FAIL rand_3[%0d]: got q=%h up=%h dn=%h tap=%h fill=%0d full=%b expected q=%h tap=%h fill=%0d",
                         n, q_3, su_3, sd_3, tap_3, fill_3, full_3, pack(mq_3), t3, f3);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; sin_up = '0; sin_dn = '0; par_in = '0; tap_sel = '0;
        test_reset();
        test_shift_up();
        test_shift_down();
        test_load_tap();
        test_enable_hold();
        test_reset_priority();
        test_rotate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8: bits per stage (lane width), WIDTH >= 1.
REQ-002 Parameter DEPTH, default 8: number of stages, DEPTH >= 2.
REQ-003 Parameter ROTATE, default 0: 1 selects circular shifting; serial inputs are then ignored.
REQ-004 Derived widths: TAP_W = clog2(DEPTH); CNT_W = clog2(DEPTH+1).
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 en  in  1  clock enable; when 0, all state holds except reset.
REQ-009 mode  in  2  00 hold, 01 shift up, 10 shift down, 11 parallel load.
REQ-010 sin_up  in  WIDTH  lane entering stage 0 on shift up.
REQ-011 sin_dn  in  WIDTH  lane entering stage DEPTH-1 on shift down.
REQ-012 par_in  in  WIDTH*DEPTH  load data; stage k = bits [k*WIDTH +: WIDTH].
REQ-013 tap_sel  in  TAP_W  stage index for tap_out.
REQ-014 q  out  WIDTH*DEPTH  all stages, same packing as par_in.
REQ-015 sout_up  out  WIDTH  stage DEPTH-1 (combinational from state).
REQ-016 sout_dn  out  WIDTH  stage 0 (combinational from state).
REQ-017 tap_out  out  WIDTH  registered copy of stage[tap_sel].
REQ-018 fill  out  CNT_W  count of valid stages, saturating at DEPTH.
REQ-019 full  out  1  high iff fill == DEPTH.

Function
REQ-020 All state SHALL update only on rising clk; q, sout_up, sout_dn, fill, full reflect registered state directly.
REQ-021 Shift up (en=1, mode=01): stage[k] <= stage[k-1] for k>=1; stage[0] <= sin_up (ROTATE=0) or old stage[DEPTH-1] (ROTATE=1).
REQ-022 Shift down (en=1, mode=10): stage[k] <= stage[k+1] for k<=DEPTH-2; stage[DEPTH-1] <= sin_dn (ROTATE=0) or old stage[0] (ROTATE=1).
REQ-023 Parallel load (en=1, mode=11): all stages <= par_in in one cycle.
REQ-024 Hold (mode=00) or en=0: stages, fill unchanged.
REQ-025 fill (ROTATE=0): +1 on each enabled shift, saturating at DEPTH; set to DEPTH on load; unchanged on hold/en=0.
REQ-026 fill (ROTATE=1): set to DEPTH on load; unchanged on shifts (no new data enters).
REQ-027 Shift direction SHALL NOT affect fill; up and down shifts both count.
REQ-028 tap_out SHALL be stage[tap_sel] sampled from pre-edge state each cycle irrespective of en/mode, i.e. one cycle latency.
REQ-029 tap_sel >= DEPTH (non-power-of-two DEPTH) SHALL yield tap_out = 0.
REQ-030 Mode decode SHALL be full; no X propagation from any legal mode value.
REQ-031 Shifting with fill == DEPTH SHALL continue normally; the outgoing stage is discarded, fill stays DEPTH.

Reset
REQ-032 When rst=1 at a rising edge: all stages, tap_out, fill SHALL become 0; full SHALL be 0.
REQ-033 rst SHALL take priority over en and every mode, including mid-shift and mid-load.
REQ-034 Output values before the first reset edge are unspecified; the bench SHALL not check them.

Verification (WIDTH=8, DEPTH=4, ROTATE=0 unless stated)
REQ-035 Reset then 4 shift-up cycles sin_up=11,22,33,44 -> q stages[3:0]=11,22,33,44 (stage0=44), fill 1,2,3,4, full high after 4th edge.
REQ-036 From REQ-035 state, 2 shift-down cycles sin_dn=AA,BB -> stages[3:0]=BB,AA,11,22; sout_dn=22; fill stays 4.
REQ-037 Load par_in=0x04030201 -> stage0=01, stage3=04, fill=4 in one cycle; next cycle tap_sel=2 -> tap_out=03 one cycle later.
REQ-038 en=0 with mode=01 for 3 cycles -> q, fill unchanged; tap_out still tracks tap_sel.
REQ-039 rst asserted with en=1, mode=11 mid-sequence -> q=0, fill=0, full=0, tap_out=0 after that edge.
REQ-040 ROTATE=1: load 0x04030201, shift up once -> stages[3:0]=03,02,01,04; shift down once -> back to 0x04030201; fill stays 4.
